// File: rtl/norm_pow2_seq.sv
// norm_pow2_seq: iterative normaliser for signed two's-complement fractions.
//
// A start request loads the operand into a working register, which is then
// shifted left (zero fill) one position per clock until its two top bits
// differ or WIDTH-1 shifts have been applied. The finished word, the shift
// count (exp) and the decoded scale factor 2^-exp are then registered and
// flagged with a single-cycle done pulse.
//
// Optional build macro NORM_FAST_EN: the NORM state looks two positions ahead
// and shifts by two whenever that cannot overshoot the normalised position.
// The results are identical; only the latency changes.
module norm_pow2_seq #(
  parameter int WIDTH = 24,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic [SHW-1:0]   exp,
  output logic [WIDTH-1:0] scale,
  output logic             zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NORM = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Largest shift count; a zero or all-ones operand stops here.
  localparam logic [SHW-1:0] CNT_MAX = SHW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q,  work_d;
  logic [SHW-1:0]   count_q, count_d;
  logic             ready_q, ready_d;
  logic             done_q,  done_d;
  logic [WIDTH-1:0] dout_q,  dout_d;
  logic [SHW-1:0]   exp_q,   exp_d;
  logic [WIDTH-1:0] scale_q, scale_d;
  logic             zero_q,  zero_d;

  logic norm_now;
  logic stop_now;

  // Decode 2^-e as a signed fraction: bit (WIDTH-1-e) set. e=0 would need
  // the value 1.0, which a signed fraction cannot hold, so it decodes to 0.
  function automatic logic [WIDTH-1:0] scale_of(input logic [SHW-1:0] e);
    logic [WIDTH-1:0] s;
    s = '0;
    for (int i = 1; i < WIDTH; i++) begin
      if (e == SHW'(i)) s[WIDTH-1-i] = 1'b1;
    end
    return s;
  endfunction

  // Normalisation test on the current working word.
  always_comb begin
    norm_now = work_q[WIDTH-1] ^ work_q[WIDTH-2];
    stop_now = norm_now || (count_q == CNT_MAX);
  end

`ifdef NORM_FAST_EN
  logic norm_next;
  logic fast_ok;

  // Look-ahead: would the word one shift further already be normalised?
  always_comb begin
    norm_next = work_q[WIDTH-2] ^ work_q[WIDTH-3];
    fast_ok   = !norm_next && (count_q <= (CNT_MAX - SHW'(2)));
  end
`endif

  // Next-state and next-output logic for the IDLE -> NORM -> DONE sequence.
  always_comb begin
    // NOTE: every variable gets a hold/default value up front so that no
    // path through the case leaves one unassigned and a latch is inferred.
    state_d = state_q;
    work_d  = work_q;
    count_d = count_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    dout_d  = dout_q;
    exp_d   = exp_q;
    scale_d = scale_q;
    zero_d  = zero_q;

    unique case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        // abort has priority over a coincident start.
        if (start && !abort) begin
          work_d  = din;
          count_d = '0;
          ready_d = 1'b0;
          state_d = S_NORM;
        end
      end

      S_NORM: begin
        if (abort) begin
          // Cancel: result registers keep the previous operation's values.
          ready_d = 1'b1;
          state_d = S_IDLE;
        end else if (stop_now) begin
          dout_d  = work_q;
          exp_d   = count_q;
          scale_d = scale_of(count_q);
          zero_d  = (work_q == '0);
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
`ifdef NORM_FAST_EN
          if (fast_ok) begin
            work_d  = work_q << 2;
            count_d = count_q + SHW'(2);
          end else begin
            work_d  = work_q << 1;
            count_d = count_q + SHW'(1);
          end
`else
          work_d  = work_q << 1;
          count_d = count_q + SHW'(1);
`endif
        end
      end

      S_DONE: begin
        // done is visible for exactly this state; always back to IDLE.
        ready_d = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; asynchronous reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      // NOTE: the working register and count are reset too; they are plain
      // flops, not a memory array, and a known value keeps the datapath clean.
      state_q <= S_IDLE;
      work_q  <= '0;
      count_q <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      dout_q  <= '0;
      exp_q   <= '0;
      scale_q <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      count_q <= count_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      dout_q  <= dout_d;
      exp_q   <= exp_d;
      scale_q <= scale_d;
      zero_q  <= zero_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    ready = ready_q;
    done  = done_q;
    dout  = dout_q;
    exp   = exp_q;
    scale = scale_q;
    zero  = zero_q;
  end

endmodule
